// File: rtl/slc_txreq_lcrd_pkg.sv
// Shared CHI definitions for the SLC TXREQ path.
// Holds the REQ flit layout and the link-layer credit ceiling.
`timescale 1ns/1ps
package slc_txreq_lcrd_pkg;

  localparam int CHI_MAX_LCRD = 15;

  typedef struct packed {
    logic [7:0]  txnid;
    logic [7:0]  opcode;
    logic [31:0] addr;
  } reqflit_t;

  localparam int REQFLIT_W = $bits(reqflit_t);

endpackage

// File: rtl/slc_txreq_lcrd_sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter and a synchronous flush.
// Pointers are log2(DEPTH) bits and wrap naturally because DEPTH is a power of two.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (occupancy == OW'(DEPTH));
  assign empty   = (occupancy == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  // Flush wins over any push or pop in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/slc_txreq_lcrd.sv
// SLC TXREQ channel stage: request FIFO plus CHI L-credit counter driving the link.
// A flit launches only when a credit is held, and the link outputs are registered.
`timescale 1ns/1ps
module slc_txreq_lcrd
  import slc_txreq_lcrd_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_LCRD = CHI_MAX_LCRD
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          pin_valid,
  output logic                          pin_ready,
  input  logic [REQFLIT_W-1:0]          txreq_in,
  output logic                          txreqflitpend,
  output logic                          txreqflitv,
  output logic [REQFLIT_W-1:0]          txreqflit,
  input  logic                          txreqlcrdv,
  output logic [$clog2(MAX_LCRD+1)-1:0] lcrd_cnt,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
  output logic                          lcrd_ovf
);

  localparam int                CW      = $clog2(MAX_LCRD+1);
  localparam logic [CW-1:0]     MAX_CNT = CW'(MAX_LCRD);

  logic                 full;
  logic                 empty;
  logic                 send;
  logic                 push;
  logic [REQFLIT_W-1:0] head;

  assign pin_ready     = !full;
  assign push          = pin_valid && pin_ready && !flush;
  assign send          = !empty && (lcrd_cnt != '0) && !flush;
  // Pending is a decode of the registered occupancy, so it tracks it with no extra lag.
  assign txreqflitpend = !empty;

  sync_fifo #(
    .WIDTH (REQFLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (send),
    .flush     (flush),
    .din       (txreq_in),
    .dout      (head),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      txreqflitv <= 1'b0;
      txreqflit  <= '0;
    end else begin
      txreqflitv <= send;
      if (send) txreqflit <= head;
    end
  end

  // A return and a send in the same cycle cancel; a return at the ceiling saturates and flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lcrd_cnt <= '0;
      lcrd_ovf <= 1'b0;
    end else begin
      case ({txreqlcrdv, send})
        2'b10: begin
          if (lcrd_cnt == MAX_CNT) lcrd_ovf <= 1'b1;
          else                     lcrd_cnt <= lcrd_cnt + 1'b1;
        end
        2'b01:   lcrd_cnt <= lcrd_cnt - 1'b1;
        default: lcrd_cnt <= lcrd_cnt;
      endcase
    end
  end

endmodule

// File: doc/slc_txreq_lcrd.md
# slc_txreq_lcrd

Parametrised SLC TX request channel stage: a DEPTH-entry request FIFO plus a CHI link-layer credit counter driving the TXREQ link. Requests are accepted with a valid/ready handshake. A REQ flit is launched only when the receiver has granted an L-credit. The block sits between the SLC request-issue logic and the CHI TXREQ link pins. It adds buffering, credit flow control, flush and status that a plain one-entry pipe stage does not provide.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- MAX_LCRD, 15, max outstanding L-credits held (CHI limit 15)
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  drop all queued requests (credits preserved)
- pin_valid  in  1  upstream request valid
- pin_ready  out  1  FIFO can accept; = !full
- txreq_in  in  $bits(reqflit_t)  upstream request flit
- txreqflitpend  out  1  registered; FIFO non-empty
- txreqflitv  out  1  registered; flit valid on link this cycle
- txreqflit  out  $bits(reqflit_t)  registered link flit
- txreqlcrdv  in  1  one L-credit returned this cycle
- lcrd_cnt  out  $clog2(MAX_LCRD+1)  credits currently held
- occupancy  out  $clog2(DEPTH+1)  FIFO entries in use
- lcrd_ovf  out  1  sticky: credit returned while counter at MAX_LCRD

## Operation
- Enqueue when pin_valid && pin_ready. pin_ready = !full; there is no same-cycle bypass when full.
- send = !empty && lcrd_cnt != 0 && !flush, computed from registered state.
- On send:
  - pop the head;
  - txreqflit <= head;
  - txreqflitv <= 1.
- Otherwise txreqflitv <= 0, and txreqflit holds its last value.
- Credit counter update:
  - +1 on txreqlcrdv;
  - −1 on send;
  - both in the same cycle → unchanged.
- txreqlcrdv with lcrd_cnt == MAX_LCRD and no send: counter saturates and lcrd_ovf sets. lcrd_ovf clears only on reset.
- flush:
  - read/write pointers and occupancy go to 0 at the next edge;
  - an enqueue in the flush cycle is discarded;
  - no send occurs in the flush cycle;
  - lcrd_cnt still counts txreqlcrdv;
  - a flit already driven (txreqflitv = 1) completes normally.
- Values after reset is asserted:
  - FIFO empty, occupancy 0;
  - lcrd_cnt 0, lcrd_ovf 0;
  - txreqflitv 0, txreqflitpend 0, txreqflit all-zero;
  - pin_ready 1.
- Reset mid-operation: queued requests and held credits are discarded. The link partner re-initialises through CHI link activation, which is outside this block.

## Timing
- Enqueue at edge t0 → occupancy and txreqflitpend reflect it from t0+1.
- Earliest send decision in cycle t0+1 → txreqflitv high in cycle t0+2.
- Minimum latency pin to link is 2 cycles, provided a credit is held.
- A txreqlcrdv received in cycle c is usable in the send decision of cycle c+1.
- Throughput is one flit per cycle while credits ≥1 and the FIFO is non-empty.
- Full FIFO with a simultaneous pop: pin_ready stays 0 in that cycle and rises the next cycle.
- Pointer wrap: log2(DEPTH)-bit pointers plus a separate occupancy counter; full = (occupancy == DEPTH).

## Structure
- reqflit_t and the constant CHI_MAX_LCRD = 15 live in the shared CHI package.
- No new typedefs are local to this block.
- One sub-module: sync_fifo, parameters WIDTH and DEPTH, with ports push, pop, flush, din, dout, full, empty, occupancy. Credit counter and output registers stay in slc_txreq_lcrd.

## Test plan
- Reset → all outputs at the reset values above; pin_ready = 1, lcrd_cnt = 0.
- Enqueue 3 flits (A, B, C) with 0 credits → no txreqflitv, occupancy = 3, txreqflitpend = 1. Then pulse txreqlcrdv for 2 cycles → A and B appear on consecutive cycles, C is held, lcrd_cnt ends at 0.
- DEPTH = 4: fill with 4 flits → pin_ready = 0 and a 5th pin_valid is held. Return one credit → one pop, and pin_ready = 1 on the following cycle.
- Hold 2 credits and stream 6 flits back-to-back, with txreqlcrdv every cycle → flitv continuous, lcrd_cnt stays 2 (simultaneous +1/−1).
- Queue 3 flits with 0 credits, assert flush together with pin_valid → occupancy = 0 next cycle and the flush-cycle input is dropped. Then return 1 credit → no flitv, lcrd_cnt = 1.
- With an empty FIFO, return 16 credits → lcrd_cnt = 15 and lcrd_ovf = 1; lcrd_ovf stays 1 until reset.
